// File: rtl/ts_trailer_extract.sv
// Receive-side "PKTE" timestamp trailer extractor: strips the 19-byte trailer,
// captures its fields, checks the Ethernet FCS and emits the frame at fixed 4-cycle latency.
module ts_trailer_extract #(
   parameter int TS_OFFSET = 0,
   parameter int DEPTH     = 4
) (
   input  logic        rxc,
   input  logic        RST,
   input  logic [7:0]  rx_data,
   input  logic        rx_dv,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_sof,
   output logic        out_eof,
   output logic        ts_valid,
   output logic        ts_err,
   output logic        fcs_ok,
   output logic [7:0]  ts_port,
   output logic        ts_crc_wrong,
   output logic        ts_len_long,
   output logic        ts_len_short,
   output logic [31:0] ts_sec,
   output logic [31:0] ts_ns,
   output logic [10:0] ts_len
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_BODY, S_TRL, S_DROP} state_t;

   // One delay-line slot; eof slots carry the frame verdicts alongside.
   typedef struct packed {
      logic       valid;
      logic       keep;
      logic       sof;
      logic       eof;
      logic       fcs;
      logic       terr;
      logic [7:0] data;
   } entry_t;

   localparam logic [10:0] TS_OFF  = 11'(TS_OFFSET);
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [10:0] idx_q;
   logic [4:0]  k_q;
   logic [31:0] crc_q;
   logic        sof_done_q;
   entry_t      line_q [DEPTH];

   logic [7:0]  sh_port_q;
   logic        sh_cw_q, sh_ll_q, sh_ls_q;
   logic [31:0] sh_sec_q, sh_ns_q;
   logic [7:0]  sh_len_lo_q;

   logic [7:0]  ts_port_q;
   logic        ts_cw_q, ts_ll_q, ts_ls_q;
   logic [31:0] ts_sec_q, ts_ns_q;
   logic [10:0] ts_len_q;
   logic        ts_valid_q, merr_q;

   logic        accept, sfd, trl_byte, mark_bad, mark_hit, last_trl;
   logic        keep_in, sof_in, eof_push, trunc;
   logic [4:0]  cur_k;
   logic [7:0]  marker;
   entry_t      line_in;

   // State register
   always_ff @(posedge rxc) begin
      if (RST) state_q <= S_DROP;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (rx_dv) begin
               if (rx_data == 8'h55)      state_d = S_PRE;
               else if (rx_data == 8'hD5) state_d = S_BODY;
               else                       state_d = S_DROP;
            end
         end
         S_PRE: begin
            if (!rx_dv)                state_d = S_IDLE;
            else if (rx_data == 8'h55) state_d = S_PRE;
            else if (rx_data == 8'hD5) state_d = S_BODY;
            else                       state_d = S_DROP;
         end
         S_BODY: begin
            if (!rx_dv)                     state_d = S_IDLE;
            else if (trl_byte && !mark_bad) state_d = S_TRL;
         end
         S_TRL: begin
            if (!rx_dv)                     state_d = S_IDLE;
            else if (mark_bad || last_trl)  state_d = S_BODY;
         end
         S_DROP: begin
            if (!rx_dv) state_d = S_IDLE;
         end
         default: state_d = S_DROP;
      endcase
   end

   // Output / datapath decode
   always_comb begin
      accept   = rx_dv && (state_q == S_BODY || state_q == S_TRL);
      sfd      = rx_dv && rx_data == 8'hD5 && (state_q == S_IDLE || state_q == S_PRE);
      cur_k    = (state_q == S_TRL) ? k_q : 5'd0;
      trl_byte = accept && (state_q == S_TRL || idx_q == TS_OFF);
      case (cur_k[1:0])
         2'd0:    marker = 8'h50;
         2'd1:    marker = 8'h4B;
         2'd2:    marker = 8'h54;
         default: marker = 8'h45;
      endcase
      mark_bad = trl_byte && cur_k < 5'd4 && rx_data != marker;
      mark_hit = trl_byte && cur_k == 5'd3 && rx_data == marker;
      last_trl = trl_byte && cur_k == 5'd18;
      // Marker byte 3 and every later trailer byte enter already stripped.
      keep_in  = !(state_q == S_TRL && (cur_k >= 5'd4 || mark_hit));
      sof_in   = accept && keep_in && !sof_done_q;
      eof_push = !rx_dv && (state_q == S_BODY || state_q == S_TRL);
      trunc    = !rx_dv && state_q == S_TRL;
      line_in  = '0;
      if (accept) begin
         line_in.valid = 1'b1;
         line_in.keep  = keep_in;
         line_in.sof   = sof_in;
         line_in.data  = rx_data;
      end else if (eof_push) begin
         line_in.eof  = 1'b1;
         line_in.fcs  = (crc_q == RESIDUE);
         line_in.terr = trunc;
      end
   end

   always_ff @(posedge rxc) begin
      if (RST) begin
         idx_q       <= '0;
         k_q         <= '0;
         crc_q       <= '1;
         sof_done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
         sh_port_q   <= '0;
         sh_cw_q     <= 1'b0;
         sh_ll_q     <= 1'b0;
         sh_ls_q     <= 1'b0;
         sh_sec_q    <= '0;
         sh_ns_q     <= '0;
         sh_len_lo_q <= '0;
         ts_port_q   <= '0;
         ts_cw_q     <= 1'b0;
         ts_ll_q     <= 1'b0;
         ts_ls_q     <= 1'b0;
         ts_sec_q    <= '0;
         ts_ns_q     <= '0;
         ts_len_q    <= '0;
         ts_valid_q  <= 1'b0;
         merr_q      <= 1'b0;
      end else begin
         if (sfd) begin
            idx_q <= '0;
            crc_q <= '1;
         end else if (accept) begin
            idx_q <= (idx_q == 11'd2047) ? idx_q : idx_q + 11'd1;
            crc_q <= crc_step(crc_q, rx_data);
         end

         if (state_q == S_BODY && trl_byte)     k_q <= 5'd1;
         else if (state_q == S_TRL && accept)   k_q <= k_q + 5'd1;

         // A stripped sof entry hands the marker on to the next kept byte.
         if (sfd) sof_done_q <= 1'b0;
         else if (mark_hit && (line_q[0].sof || line_q[1].sof || line_q[2].sof)) sof_done_q <= 1'b0;
         else if (sof_in) sof_done_q <= 1'b1;

         line_q[0] <= line_in;
         for (int i = 1; i < DEPTH; i++) begin
            line_q[i] <= line_q[i-1];
            if (mark_hit) begin
               line_q[i].keep <= 1'b0;
               line_q[i].sof  <= 1'b0;
            end
         end

         if (trl_byte && state_q == S_TRL) begin
            case (k_q)
               5'd4:  sh_port_q       <= rx_data;
               5'd5:  begin sh_cw_q <= rx_data[4]; sh_ll_q <= rx_data[0]; end
               5'd6:  sh_ls_q         <= rx_data[4];
               5'd9:  sh_sec_q[7:0]   <= rx_data;
               5'd10: sh_sec_q[15:8]  <= rx_data;
               5'd11: sh_sec_q[23:16] <= rx_data;
               5'd12: sh_sec_q[31:24] <= rx_data;
               5'd13: sh_ns_q[7:0]    <= rx_data;
               5'd14: sh_ns_q[15:8]   <= rx_data;
               5'd15: sh_ns_q[23:16]  <= rx_data;
               5'd16: sh_ns_q[31:24]  <= rx_data;
               5'd17: sh_len_lo_q     <= rx_data;
               default: ;
            endcase
         end

         if (last_trl) begin
            ts_port_q <= sh_port_q;
            ts_cw_q   <= sh_cw_q;
            ts_ll_q   <= sh_ll_q;
            ts_ls_q   <= sh_ls_q;
            ts_sec_q  <= sh_sec_q;
            ts_ns_q   <= sh_ns_q;
            ts_len_q  <= {rx_data[2:0], sh_len_lo_q};
         end
         ts_valid_q <= last_trl;
         merr_q     <= mark_bad;
      end
   end

   assign out_data     = line_q[DEPTH-1].data;
   assign out_valid    = line_q[DEPTH-1].valid && line_q[DEPTH-1].keep;
   assign out_sof      = out_valid && line_q[DEPTH-1].sof;
   assign out_eof      = line_q[DEPTH-1].eof;
   assign fcs_ok       = line_q[DEPTH-1].eof && line_q[DEPTH-1].fcs;
   assign ts_err       = merr_q || (line_q[DEPTH-1].eof && line_q[DEPTH-1].terr);
   assign ts_valid     = ts_valid_q;
   assign ts_port      = ts_port_q;
   assign ts_crc_wrong = ts_cw_q;
   assign ts_len_long  = ts_ll_q;
   assign ts_len_short = ts_ls_q;
   assign ts_sec       = ts_sec_q;
   assign ts_ns        = ts_ns_q;
   assign ts_len       = ts_len_q;

endmodule

// File: tb/tb_ts_trailer_extract.sv
// Directed-frame bench for ts_trailer_extract: the driver queues expected bytes,
// end-of-frame verdicts and trailer records; a negedge monitor pops and compares them.
module tb_ts_trailer_extract;

   logic        rxc = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_dv = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid, out_sof, out_eof, ts_valid, ts_err, fcs_ok;
   logic [7:0]  ts_port;
   logic        ts_crc_wrong, ts_len_long, ts_len_short;
   logic [31:0] ts_sec, ts_ns;
   logic [10:0] ts_len;

   ts_trailer_extract #(.TS_OFFSET(0), .DEPTH(4)) dut (
      .rxc(rxc), .RST(RST), .rx_data(rx_data), .rx_dv(rx_dv),
      .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
      .ts_valid(ts_valid), .ts_err(ts_err), .fcs_ok(fcs_ok),
      .ts_port(ts_port), .ts_crc_wrong(ts_crc_wrong), .ts_len_long(ts_len_long),
      .ts_len_short(ts_len_short), .ts_sec(ts_sec), .ts_ns(ts_ns), .ts_len(ts_len)
   );

   // Clock / cycle counter
   always #4 rxc = ~rxc;
   int cyc = 0;
   always @(posedge rxc) cyc <= cyc + 1;

   // Scoreboard state
   logic [8:0]  exp_q[$];
   int          exp_cyc_q[$];
   logic [1:0]  eof_q[$];
   int          eof_cyc_q[$];
   logic [85:0] ts_q[$];
   logic [85:0] last_ts = '0;
   logic [7:0]  frm[$];
   logic [7:0]  mk[4] = '{8'h50, 8'h4B, 8'h54, 8'h45};
   int          n_cmp = 0;
   int          n_err = 0;
   int          err_pulses = 0;
   int          exp_err_pulses = 0;

   task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   function automatic logic [85:0] pack_ts(input logic [7:0] port, input logic cw, input logic ll,
                                           input logic ls, input logic [31:0] sec,
                                           input logic [31:0] ns, input logic [10:0] len);
      return {port, cw, ll, ls, sec, ns, len};
   endfunction

   function automatic logic [85:0] dut_ts();
      return {ts_port, ts_crc_wrong, ts_len_long, ts_len_short, ts_sec, ts_ns, ts_len};
   endfunction

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int b = 0; b < 8; b++) r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Monitor
   always @(negedge rxc) begin
      logic [8:0]  e;
      int          ec;
      logic [1:0]  ee;
      logic [85:0] et;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL out_byte: unexpected byte %02h, none expected (cycle %0d)", out_data, cyc);
         end else begin
            e = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            cmp("out_byte{sof,data,cycle}", {out_sof, out_data, 32'(cyc)}, {e, 32'(ec)});
         end
      end
      if (out_eof) begin
         if (eof_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL out_eof: unexpected eof, none expected (cycle %0d)", cyc);
         end else begin
            ee = eof_q.pop_front();
            ec = eof_cyc_q.pop_front();
            cmp("eof{valid,fcs_ok,ts_err,cycle}", {out_valid, fcs_ok, ts_err, 32'(cyc)},
                {1'b0, ee, 32'(ec)});
         end
      end
      if (ts_err && !out_eof) err_pulses++;
      if (ts_valid) begin
         if (ts_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL ts_valid: unexpected pulse, none expected (cycle %0d)", cyc);
         end else begin
            et = ts_q.pop_front();
            cmp("ts_fields", dut_ts(), et);
         end
      end
   end

   // Driver helpers
   task automatic tick();
      @(posedge rxc);
      #1;
   endtask

   task automatic add_trailer(input logic [7:0] port, input logic [7:0] b5, input logic [7:0] b6,
                              input logic [31:0] sec, input logic [31:0] ns,
                              input logic [7:0] b17, input logic [7:0] b18);
      frm.push_back(8'h50); frm.push_back(8'h4B); frm.push_back(8'h54); frm.push_back(8'h45);
      frm.push_back(port); frm.push_back(b5); frm.push_back(b6);
      frm.push_back(8'hA5); frm.push_back(8'h5A);
      for (int i = 0; i < 4; i++) frm.push_back(sec[8*i +: 8]);
      for (int i = 0; i < 4; i++) frm.push_back(ns[8*i +: 8]);
      frm.push_back(b17); frm.push_back(b18);
   endtask

   task automatic add_payload(input int n, input int seed);
      for (int i = 0; i < n; i++) frm.push_back(8'((i * 7 + seed) & 8'hFF));
   endtask

   task automatic add_fcs();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (frm[i]) c = crc_upd(c, frm[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
   endtask

   // Send frm with pre_len preamble bytes; rst_at >= 0 pulses RST with that post-SFD byte.
   task automatic send(input int pre_len, input int rst_at, input int gap);
      int          n, mlen, first_kept, last_cyc;
      logic        bad, strip, trunc_exp, rst_pend, rst_done;
      logic [31:0] c;
      n = frm.size();
      mlen = (n < 4) ? n : 4;
      bad = 1'b0;
      for (int j = 0; j < mlen; j++) if (frm[j] != mk[j]) bad = 1'b1;
      if (bad) exp_err_pulses++;
      strip = (n >= 4) && !bad;
      trunc_exp = (n >= 1) && (n < 19) && !bad;
      first_kept = strip ? 19 : 0;
      c = 32'hFFFFFFFF;
      foreach (frm[i]) c = crc_upd(c, frm[i]);
      rst_pend = 1'b0;
      rst_done = 1'b0;
      for (int p = 0; p < pre_len; p++) begin
         tick(); rx_dv = 1'b1; rx_data = 8'h55;
      end
      tick(); rx_dv = 1'b1; rx_data = 8'hD5;
      last_cyc = cyc;
      for (int i = 0; i < n; i++) begin
         tick();
         if (rst_pend) begin
            RST = 1'b0; rst_pend = 1'b0;
            cmp("post_reset_outputs",
                {out_valid, out_sof, out_eof, out_data, ts_valid, ts_err, fcs_ok, dut_ts()}, '0);
            last_ts = '0;
         end
         rx_data = frm[i];
         last_cyc = cyc;
         if (i == rst_at) begin RST = 1'b1; rst_pend = 1'b1; rst_done = 1'b1; end
         if (!(strip && i < 19) && (rst_at < 0 || i <= rst_at - 4)) begin
            exp_q.push_back({(i == first_kept), frm[i]});
            exp_cyc_q.push_back(last_cyc + 4);
         end
      end
      if (!rst_done) begin
         eof_q.push_back({(c == 32'hDEBB20E3), trunc_exp});
         eof_cyc_q.push_back(last_cyc + 5);
      end
      tick();
      if (rst_pend) begin
         RST = 1'b0;
         cmp("post_reset_outputs",
             {out_valid, out_sof, out_eof, out_data, ts_valid, ts_err, fcs_ok, dut_ts()}, '0);
         last_ts = '0;
      end
      rx_dv = 1'b0; rx_data = 8'h00;
      for (int g = 1; g < gap; g++) tick();
   endtask

   initial begin
      // Reset state
      tick(); tick(); tick();
      cmp("reset_outputs",
          {out_valid, out_sof, out_eof, out_data, ts_valid, ts_err, fcs_ok, dut_ts()}, '0);
      RST = 1'b0;
      tick(); tick();

      // Clean trailer, 60 payload bytes, good FCS
      frm.delete();
      add_trailer(8'h00, 8'h11, 8'h10, 32'h12345678, 32'h3B9AC9F0, 8'hDC, 8'h05);
      add_payload(60, 3);
      add_fcs();
      last_ts = pack_ts(8'h00, 1'b1, 1'b1, 1'b1, 32'h12345678, 32'h3B9AC9F0, 11'h5DC);
      ts_q.push_back(last_ts);
      send(7, -1, 12);
      cmp("ts_after_clean", dut_ts(), last_ts);

      // Marker mismatch at trailer byte 2: frame passes unstripped
      frm.delete();
      frm.push_back(8'h50); frm.push_back(8'h4B); frm.push_back(8'h00);
      add_payload(40, 11);
      add_fcs();
      send(7, -1, 12);
      cmp("ts_hold_mismatch", dut_ts(), last_ts);
      cmp("mismatch_err_pulses", 128'(err_pulses), 128'(exp_err_pulses));

      // Truncated at trailer byte 10
      frm.delete();
      add_trailer(8'h99, 8'h11, 8'h10, 32'hCAFEF00D, 32'h00000007, 8'h10, 8'h01);
      while (frm.size() > 10) void'(frm.pop_back());
      send(7, -1, 12);
      cmp("ts_hold_trunc", dut_ts(), last_ts);

      // Corrupted FCS: one payload bit flipped after the FCS was appended
      frm.delete();
      add_trailer(8'h3C, 8'hEE, 8'hEF, 32'hDEADBEEF, 32'h00000001, 8'h34, 8'hFA);
      add_payload(46, 5);
      add_fcs();
      frm[25] = frm[25] ^ 8'h08;
      last_ts = pack_ts(8'h3C, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00000001, 11'h234);
      ts_q.push_back(last_ts);
      send(7, -1, 12);

      // Back-to-back frames with a 1-cycle gap
      frm.delete();
      add_trailer(8'h81, 8'h01, 8'h00, 32'h00000001, 32'h00000002, 8'h40, 8'h00);
      add_payload(10, 1);
      add_fcs();
      ts_q.push_back(pack_ts(8'h81, 1'b0, 1'b1, 1'b0, 32'h00000001, 32'h00000002, 11'h040));
      send(7, -1, 1);
      frm.delete();
      add_trailer(8'h02, 8'h10, 8'h10, 32'hFFFFFFFF, 32'h80000000, 8'hFF, 8'h07);
      add_payload(5, 9);
      add_fcs();
      last_ts = pack_ts(8'h02, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h80000000, 11'h7FF);
      ts_q.push_back(last_ts);
      send(3, -1, 12);

      // Empty frame: SFD then rx_dv drops
      frm.delete();
      send(7, -1, 12);

      // Reset pulse at post-SFD byte 30
      frm.delete();
      add_trailer(8'h55, 8'h00, 8'h00, 32'h01020304, 32'h05060708, 8'h22, 8'h00);
      add_payload(40, 17);
      add_fcs();
      ts_q.push_back(pack_ts(8'h55, 1'b0, 1'b0, 1'b0, 32'h01020304, 32'h05060708, 11'h022));
      send(7, 30, 12);
      cmp("ts_cleared_by_reset", dut_ts(), last_ts);

      // Normal frame after reset
      frm.delete();
      add_trailer(8'h07, 8'h10, 8'h01, 32'h0BADF00D, 32'h3B9AC9FF, 8'h01, 8'h00);
      add_payload(20, 23);
      add_fcs();
      last_ts = pack_ts(8'h07, 1'b1, 1'b0, 1'b0, 32'h0BADF00D, 32'h3B9AC9FF, 11'h001);
      ts_q.push_back(last_ts);
      send(7, -1, 12);

      for (int i = 0; i < 200 && (exp_q.size() + eof_q.size() + ts_q.size()) != 0; i++) tick();
      cmp("leftover_bytes", 128'(exp_q.size()), 128'd0);
      cmp("leftover_eofs", 128'(eof_q.size()), 128'd0);
      cmp("leftover_ts", 128'(ts_q.size()), 128'd0);
      cmp("ts_err_pulses", 128'(err_pulses), 128'(exp_err_pulses));
      cmp("ts_final_hold", dut_ts(), last_ts);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
